// File: rtl/snoop_bus_pkg.sv
// ============================================================================
//  Module      : snoop_bus_pkg
//  Description : Shared types and helpers for the snooping-bus arbiter and
//                its round-robin picker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snoop_bus_pkg;

    // Width of the broadcast snoop address
    localparam int ADDR_W = 32;

    // Bus sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    // Width of an index into n requesters (never zero, even for n == 1)
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : snoop_bus_pkg

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin priority picker. Returns the first
//                set request at or above the pointer, wrapping to bit 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import snoop_bus_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Two passes: first the requesters at or above the pointer, then the wrap
    always_comb begin
        win   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (i >= int'(ptr))) begin
                win[i] = 1'b1;
                idx    = IDX_W'(i);
                valid  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i]) begin
                win[i] = 1'b1;
                idx    = IDX_W'(i);
                valid  = 1'b1;
            end
        end
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/snoop_bus_arbiter.sv
// ============================================================================
//  Module      : snoop_bus_arbiter
//  Description : Round-robin arbiter for the shared snooping bus. Grants one
//                cache at a time, bounds tenure to MAX_HOLD cycles, inserts a
//                turnaround cycle between owners and broadcasts the owner's
//                address and invalidate.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snoop_bus_arbiter
    import snoop_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_HOLD    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            req,
    input  logic [ADDR_W*NUM_MASTERS-1:0]     addrIn,
    input  logic [NUM_MASTERS-1:0]            invalidateIn,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic [NUM_MASTERS-1:0]            master,
    output logic [ADDR_W-1:0]                 addrSnoop,
    output logic                              invalidateOut,
    output logic [idx_w(NUM_MASTERS)-1:0]     ownerId,
    output logic                              busBusy
);

    localparam int IDX_W  = idx_w(NUM_MASTERS);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    state_t                 r_state, w_nxt_state;
    logic [NUM_MASTERS-1:0] r_grant, w_nxt_grant;
    logic [IDX_W-1:0]       r_owner, w_nxt_owner;
    logic [IDX_W-1:0]       r_ptr,   w_nxt_ptr;
    logic [HOLD_W-1:0]      r_hold,  w_nxt_hold;
    logic                   r_busy,  w_nxt_busy;

    logic [NUM_MASTERS-1:0] w_win;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_valid;
    logic [ADDR_W-1:0]      w_addr [NUM_MASTERS];

    rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .win   (w_win),
        .idx   (w_idx),
        .valid (w_valid)
    );

    // Split the flat address bus into one word per master
    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_addr
        assign w_addr[g] = addrIn[g*ADDR_W +: ADDR_W];
    end

    // Register state, pointer, hold counter and all registered outputs together
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_grant <= w_nxt_grant;
            r_owner <= w_nxt_owner;
            r_ptr   <= w_nxt_ptr;
            r_hold  <= w_nxt_hold;
            r_busy  <= w_nxt_busy;
        end
    end

    // Next-state: arbitrate in IDLE, release on drop or timeout, one dead TURN cycle
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_owner = r_owner;
        w_nxt_ptr   = r_ptr;
        w_nxt_hold  = r_hold;
        w_nxt_busy  = r_busy;
        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_nxt_state = OWN;
                    w_nxt_grant = w_win;
                    w_nxt_owner = w_idx;
                    w_nxt_busy  = 1'b1;
                    w_nxt_hold  = HOLD_W'(1);
                    // Winner drops to lowest priority for the next round
                    w_nxt_ptr   = (w_idx == IDX_W'(NUM_MASTERS - 1)) ? '0
                                                                     : w_idx + IDX_W'(1);
                end
            end
            OWN: begin
                // Voluntary release and timeout take the same path
                if (!req[r_owner] || (r_hold == HOLD_W'(MAX_HOLD))) begin
                    w_nxt_state = TURN;
                    w_nxt_grant = '0;
                    w_nxt_owner = '0;
                    w_nxt_busy  = 1'b0;
                    w_nxt_hold  = '0;
                end else begin
                    w_nxt_hold  = r_hold + HOLD_W'(1);
                end
            end
            TURN: begin
                w_nxt_state = IDLE;
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_grant = '0;
                w_nxt_owner = '0;
                w_nxt_busy  = 1'b0;
                w_nxt_hold  = '0;
            end
        endcase
    end

    // Broadcast the owner's address and invalidate; quiet unless the bus is owned
    always_comb begin
        addrSnoop     = '0;
        invalidateOut = 1'b0;
        if (r_state == OWN) begin
            addrSnoop     = w_addr[r_owner];
            invalidateOut = invalidateIn[r_owner];
        end
    end

    assign grant   = r_grant;
    assign master  = r_grant;
    assign ownerId = r_owner;
    assign busBusy = r_busy;

endmodule : snoop_bus_arbiter

`default_nettype wire
